darkarb: RTL and testbench
==========================

DARKARB -- requirements
Module: darkarb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the number of BUSY cycles without m_valid before the transfer is aborted.
REQ-002 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port res, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have, for N in {0,1} (0 = data/darkmem, 1 = instruction fetch):
- rN_en, input, 1: request, held high until rN_valid.
- rN_rw, input, 1: 1 = write.
- rN_be, input, 4: byte enables.
- rN_addr, input, 32: address.
- rN_wdata, input, 32: write data.
- rN_valid, output, 1: one-cycle completion pulse.
- rN_rdata, output, 32: read data.
- rN_err, output, 1: timeout flag, qualified by rN_valid.
REQ-006 SHALL have downstream ports:
- m_en, output, 1: transfer active.
- m_rw, output, 1: 1 = write.
- m_be, output, 4: byte enables.
- m_addr, output, 32: address.
- m_wdata, output, 32: write data.
- m_valid, input, 1: provider completion.
- m_rdata, input, 32: provider read data.

Function
REQ-007 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-008 In IDLE with any rN_en high at a clock edge, SHALL select a winner, latch its rw/be/addr/wdata into the m_* registers, set m_en=1 and m_rw, and enter BUSY; m_en is high from the next cycle.
REQ-009 With RR=1 and both requesters active, SHALL grant the requester not granted last; the last-granted register resets to 1, so requester 0 wins the first tie.
REQ-010 With RR=0 and both requesters active, SHALL always grant requester 0.
REQ-011 SHALL hold m_* outputs constant throughout BUSY, independent of requester inputs.
REQ-012 In BUSY with m_valid=1, SHALL:
- clear m_en and m_rw;
- register m_rdata into the winner's rN_rdata on reads only (rN_rdata unchanged on writes);
- pulse the winner's rN_valid for exactly one cycle with rN_err=0;
- enter DONE.
REQ-013 In BUSY, SHALL increment a cycle counter each cycle m_valid=0; at the cycle in which the counter equals TIMEOUT-1, SHALL clear m_en, pulse the winner's rN_valid with rN_err=1, set rN_rdata=0 on reads, and enter DONE.
REQ-014 m_valid arriving in the same cycle as the timeout SHALL take precedence: normal completion with rN_err=0.
REQ-015 DONE SHALL last exactly one cycle with m_en=0 and no grant, then return to IDLE, allowing the requester to drop rN_en.
REQ-016 m_valid while in IDLE or DONE SHALL be ignored.
REQ-017 rN_en dropping while in BUSY SHALL NOT abort the transfer; completion is still signalled.
REQ-018 The loser's rN_valid SHALL stay 0; the loser is served on the next IDLE.
REQ-019 Minimum latency SHALL be: request at edge k, m_en high in cycle k+1, m_valid sampled at edge k+1, rN_valid high in cycle k+2. Back-to-back grants SHALL be spaced at least 3 cycles apart.
REQ-020 The counter SHALL be sized as $clog2(TIMEOUT+1) bits, clear on each grant, and never wrap.

Reset
REQ-021 res high SHALL immediately force state to IDLE, with m_en, m_rw, m_be, m_addr, m_wdata, rN_valid, rN_rdata, rN_err and the counter all 0, and last-granted set to 1.
REQ-022 Reset asserted mid-BUSY SHALL drop m_en asynchronously, with no rN_valid pulse issued.

Structure
REQ-023 The state typedef (IDLE/BUSY/DONE) and a default TIMEOUT constant SHALL reside in the shared package darkbus_pkg.
REQ-024 The grant decision SHALL be a combinational sub-module darkarb_pick (inputs: r0_en, r1_en, last, RR; output: winner).

Verification
REQ-025 r0 read addr 0x100, provider m_valid after 2 cycles with m_rdata 0xCAFEF00D -> m_addr=0x100, m_rw=0, r0_valid one pulse, r0_rdata=0xCAFEF00D, r0_err=0.
REQ-026 r0 and r1 both request in the same cycle, RR=1, reset just released -> r0 granted first; r1 granted at the next IDLE; grants 0,1,0,1 over four persistent requests.
REQ-027 Same stimulus with RR=0 and r0_en held permanently -> r1 never granted.
REQ-028 r1 write of 0x12345678 with be=4'b0011, TIMEOUT=4, no m_valid -> m_en high for 4 cycles, then r1_valid with r1_err=1.
REQ-029 m_valid on exactly the timeout cycle -> r*_err=0 and read data captured.
REQ-030 res asserted in the second BUSY cycle -> m_en=0 immediately, no rN_valid, next request granted normally after release.

Source files
------------

// File: rtl/darkbus_pkg.sv
// Shared definitions for the dark bus arbiter.
// Holds the arbiter FSM state type and the default abort timeout.
package darkbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/darkarb_pick.sv
// Grant decision for the two-requester arbiter.
// Ports: r0_en/r1_en requests, last = index granted last,
//        rr = round-robin enable, winner = granted index.
module darkarb_pick (
    input  logic r0_en,
    input  logic r1_en,
    input  logic last,
    input  logic rr,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (r0_en && r1_en) begin
            // On a tie, round-robin favours whoever did not win last time.
            winner = rr ? ~last : 1'b0;
        end else if (r1_en) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/darkarb.sv
// Two-port arbiter (0 = data, 1 = fetch) onto one downstream bus,
// with a per-transfer abort timeout.
// Ports: clk, res (async active-high), r0_*/r1_* requester side,
//        m_* downstream side.
module darkarb
    import darkbus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int RR      = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        r0_en,
    input  logic        r0_rw,
    input  logic [3:0]  r0_be,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_valid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_en,
    input  logic        r1_rw,
    input  logic [3:0]  r1_be,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_valid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic        m_en,
    output logic        m_rw,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_valid,
    input  logic [31:0] m_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          m_en_q, m_en_d;
    logic          m_rw_q, m_rw_d;
    logic [3:0]    m_be_q, m_be_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic          e0_q, e0_d, e1_q, e1_d;
    logic [31:0]   rd0_q, rd0_d, rd1_q, rd1_d;
    logic          pick;

    darkarb_pick u_pick (
        .r0_en  (r0_en),
        .r1_en  (r1_en),
        .last   (last_q),
        .rr     (RR != 0),
        .winner (pick)
    );

    always_comb begin
        state_d   = state_q;
        m_en_d    = m_en_q;
        m_rw_d    = m_rw_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        win_d     = win_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        v0_d      = 1'b0;
        v1_d      = 1'b0;
        e0_d      = 1'b0;
        e1_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (r0_en || r1_en) begin
                    state_d   = BUSY;
                    win_d     = pick;
                    last_d    = pick;
                    cnt_d     = '0;
                    m_en_d    = 1'b1;
                    m_rw_d    = pick ? r1_rw    : r0_rw;
                    m_be_d    = pick ? r1_be    : r0_be;
                    m_addr_d  = pick ? r1_addr  : r0_addr;
                    m_wdata_d = pick ? r1_wdata : r0_wdata;
                end
            end
            BUSY: begin
                // Completion beats timeout when both land together.
                if (m_valid) begin
                    state_d = DONE;
                    m_en_d  = 1'b0;
                    m_rw_d  = 1'b0;
                    if (win_q) begin
                        v1_d = 1'b1;
                        if (!m_rw_q) rd1_d = m_rdata;
                    end else begin
                        v0_d = 1'b1;
                        if (!m_rw_q) rd0_d = m_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    m_en_d  = 1'b0;
                    m_rw_d  = 1'b0;
                    if (win_q) begin
                        v1_d = 1'b1;
                        e1_d = 1'b1;
                        if (!m_rw_q) rd1_d = '0;
                    end else begin
                        v0_d = 1'b1;
                        e0_d = 1'b1;
                        if (!m_rw_q) rd0_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q   <= IDLE;
            m_en_q    <= 1'b0;
            m_rw_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            e0_q      <= 1'b0;
            e1_q      <= 1'b0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_en_q    <= m_en_d;
            m_rw_q    <= m_rw_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            win_q     <= win_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            e0_q      <= e0_d;
            e1_q      <= e1_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign m_en     = m_en_q;
    assign m_rw     = m_rw_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign r0_valid = v0_q;
    assign r1_valid = v1_q;
    assign r0_err   = e0_q;
    assign r1_err   = e1_q;
    assign r0_rdata = rd0_q;
    assign r1_rdata = rd1_q;

endmodule

// File: tb/tb_darkarb.sv
// Directed bench for darkarb: a round-robin instance (a_*) and a
// fixed-priority instance (b_*) share the same stimulus.
module tb_darkarb;

    logic        clk = 1'b0;
    logic        res;
    logic        r0_en, r0_rw, r1_en, r1_rw;
    logic [3:0]  r0_be, r1_be;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        m_valid;
    logic [31:0] m_rdata;

    logic        a_r0_valid, a_r0_err, a_r1_valid, a_r1_err;
    logic [31:0] a_r0_rdata, a_r1_rdata;
    logic        a_m_en, a_m_rw;
    logic [3:0]  a_m_be;
    logic [31:0] a_m_addr, a_m_wdata;

    logic        b_r0_valid, b_r0_err, b_r1_valid, b_r1_err;
    logic [31:0] b_r0_rdata, b_r1_rdata;
    logic        b_m_en, b_m_rw;
    logic [3:0]  b_m_be;
    logic [31:0] b_m_addr, b_m_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    darkarb #(.TIMEOUT(4), .RR(1)) u_a (
        .clk(clk), .res(res),
        .r0_en(r0_en), .r0_rw(r0_rw), .r0_be(r0_be),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_valid(a_r0_valid), .r0_rdata(a_r0_rdata), .r0_err(a_r0_err),
        .r1_en(r1_en), .r1_rw(r1_rw), .r1_be(r1_be),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_valid(a_r1_valid), .r1_rdata(a_r1_rdata), .r1_err(a_r1_err),
        .m_en(a_m_en), .m_rw(a_m_rw), .m_be(a_m_be),
        .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_valid(m_valid), .m_rdata(m_rdata)
    );

    darkarb #(.TIMEOUT(4), .RR(0)) u_b (
        .clk(clk), .res(res),
        .r0_en(r0_en), .r0_rw(r0_rw), .r0_be(r0_be),
        .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_valid(b_r0_valid), .r0_rdata(b_r0_rdata), .r0_err(b_r0_err),
        .r1_en(r1_en), .r1_rw(r1_rw), .r1_be(r1_be),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_valid(b_r1_valid), .r1_rdata(b_r1_rdata), .r1_err(b_r1_err),
        .m_en(b_m_en), .m_rw(b_m_rw), .m_be(b_m_be),
        .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_valid(m_valid), .m_rdata(m_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        res = 1'b1;
        step();
        res = 1'b0;
    endtask

    // Wait (bounded) for a grant, complete it after one BUSY cycle,
    // and report which completion pulses fired.
    task automatic serve(output bit ok, output logic a0, output logic a1,
                         output logic b0, output logic b1,
                         output logic [31:0] addr);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (a_m_en) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        addr = a_m_addr;
        m_valid = 1'b1;
        step();
        a0 = a_r0_valid;
        a1 = a_r1_valid;
        b0 = b_r0_valid;
        b1 = b_r1_valid;
        m_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        res = 1'b1;
        step();
        checks++; if (a_m_en !== 1'b0) begin errors++; $display("FAIL rst_m_en got %b want 0", a_m_en); end
        checks++; if (a_m_addr !== 32'h0) begin errors++; $display("FAIL rst_m_addr got %h want 0", a_m_addr); end
        checks++; if (a_r0_valid !== 1'b0) begin errors++; $display("FAIL rst_r0_valid got %b want 0", a_r0_valid); end
        checks++; if (a_r1_rdata !== 32'h0) begin errors++; $display("FAIL rst_r1_rdata got %h want 0", a_r1_rdata); end
        res = 1'b0;
    endtask

    task automatic test_read();
        r0_en = 1'b1; r0_rw = 1'b0; r0_addr = 32'h100; r0_be = 4'hF;
        step();
        checks++; if (a_m_en !== 1'b1) begin errors++; $display("FAIL rd_m_en got %b want 1", a_m_en); end
        checks++; if (a_m_addr !== 32'h100) begin errors++; $display("FAIL rd_m_addr got %h want 100", a_m_addr); end
        checks++; if (a_m_rw !== 1'b0) begin errors++; $display("FAIL rd_m_rw got %b want 0", a_m_rw); end
        r0_en = 1'b0;
        r0_addr = 32'h999;
        step();
        checks++; if (a_m_en !== 1'b1 || a_m_addr !== 32'h100) begin errors++; $display("FAIL rd_hold got en=%b addr=%h want 1/100", a_m_en, a_m_addr); end
        checks++; if (a_r0_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got %b want 0", a_r0_valid); end
        m_valid = 1'b1; m_rdata = 32'hCAFEF00D;
        step();
        checks++; if (a_r0_valid !== 1'b1) begin errors++; $display("FAIL rd_valid got %b want 1", a_r0_valid); end
        checks++; if (a_r0_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_rdata got %h want cafef00d", a_r0_rdata); end
        checks++; if (a_r0_err !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", a_r0_err); end
        checks++; if (a_m_en !== 1'b0 || a_r1_valid !== 1'b0) begin errors++; $display("FAIL rd_done got en=%b v1=%b want 0/0", a_m_en, a_r1_valid); end
        m_valid = 1'b0;
        step();
        checks++; if (a_r0_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_len got %b want 0", a_r0_valid); end
        m_valid = 1'b1; m_rdata = 32'hDEADBEEF;
        step();
        step();
        checks++; if (a_r0_valid !== 1'b0 || a_r0_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL idle_mvalid got v=%b d=%h want 0/cafef00d", a_r0_valid, a_r0_rdata); end
        m_valid = 1'b0;
    endtask

    task automatic test_arbitration();
        bit ok;
        logic a0, a1, b0, b1;
        logic [31:0] addr;
        pulse_reset();
        r0_en = 1'b1; r0_rw = 1'b0; r0_addr = 32'h200;
        r1_en = 1'b1; r1_rw = 1'b0; r1_addr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            serve(ok, a0, a1, b0, b1, addr);
            checks++; if (!ok) begin errors++; $display("FAIL arb_grant%0d got no m_en want grant", g); end
            checks++; if (a0 !== ((g % 2) == 0) || a1 !== ((g % 2) == 1)) begin errors++; $display("FAIL rr_grant%0d got v0=%b v1=%b want %0d", g, a0, a1, g % 2); end
            checks++; if (addr !== (((g % 2) == 1) ? 32'h300 : 32'h200)) begin errors++; $display("FAIL rr_addr%0d got %h", g, addr); end
            checks++; if (b0 !== 1'b1 || b1 !== 1'b0) begin errors++; $display("FAIL fixed_grant%0d got v0=%b v1=%b want 1/0", g, b0, b1); end
        end
        r0_en = 1'b0; r1_en = 1'b0;
        step();
    endtask

    task automatic test_timeout_write();
        bit ok;
        logic a0, a1, b0, b1;
        logic [31:0] addr;
        int n;
        pulse_reset();
        r1_en = 1'b1; r1_rw = 1'b0; r1_addr = 32'h400; m_rdata = 32'hA5A50001;
        serve(ok, a0, a1, b0, b1, addr);
        checks++; if (!ok || a1 !== 1'b1 || a_r1_rdata !== 32'hA5A50001) begin errors++; $display("FAIL r1_read got ok=%b v1=%b d=%h want 1/1/a5a50001", ok, a1, a_r1_rdata); end
        r1_rw = 1'b1; r1_be = 4'b0011; r1_addr = 32'h500; r1_wdata = 32'h12345678;
        step();
        checks++; if (a_m_wdata !== 32'h12345678 || a_m_be !== 4'b0011 || a_m_rw !== 1'b1) begin errors++; $display("FAIL wr_fields got wd=%h be=%b rw=%b", a_m_wdata, a_m_be, a_m_rw); end
        n = 0;
        while (a_m_en && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL to_cycles got %0d want 4", n); end
        checks++; if (a_r1_valid !== 1'b1 || a_r1_err !== 1'b1) begin errors++; $display("FAIL to_flag got v=%b e=%b want 1/1", a_r1_valid, a_r1_err); end
        checks++; if (a_r1_rdata !== 32'hA5A50001 || a_r0_valid !== 1'b0) begin errors++; $display("FAIL to_wr_keep got d=%h v0=%b want a5a50001/0", a_r1_rdata, a_r0_valid); end
        r1_en = 1'b0; r1_rw = 1'b0;
        step();
    endtask

    task automatic test_timeout_edge();
        int n;
        r0_en = 1'b1; r0_rw = 1'b0; r0_addr = 32'h600;
        step();
        step();
        step();
        step();
        checks++; if (a_m_en !== 1'b1 || a_r0_valid !== 1'b0) begin errors++; $display("FAIL edge_busy got en=%b v=%b want 1/0", a_m_en, a_r0_valid); end
        m_valid = 1'b1; m_rdata = 32'h5EED0004;
        step();
        checks++; if (a_r0_valid !== 1'b1 || a_r0_err !== 1'b0) begin errors++; $display("FAIL edge_flag got v=%b e=%b want 1/0", a_r0_valid, a_r0_err); end
        checks++; if (a_r0_rdata !== 32'h5EED0004) begin errors++; $display("FAIL edge_rdata got %h want 5eed0004", a_r0_rdata); end
        m_valid = 1'b0; r0_en = 1'b0;
        step();
        r0_en = 1'b1;
        step();
        n = 0;
        while (a_m_en && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== 4 || a_r0_err !== 1'b1) begin errors++; $display("FAIL to_read got n=%0d e=%b want 4/1", n, a_r0_err); end
        checks++; if (a_r0_rdata !== 32'h0) begin errors++; $display("FAIL to_read_data got %h want 0", a_r0_rdata); end
        r0_en = 1'b0;
        step();
    endtask

    task automatic test_reset_busy();
        r0_en = 1'b1; r0_rw = 1'b0; r0_addr = 32'h700;
        step();
        step();
        checks++; if (a_m_en !== 1'b1) begin errors++; $display("FAIL rb_busy got %b want 1", a_m_en); end
        res = 1'b1;
        #1;
        checks++; if (a_m_en !== 1'b0 || a_r0_valid !== 1'b0) begin errors++; $display("FAIL rb_async got en=%b v=%b want 0/0", a_m_en, a_r0_valid); end
        step();
        res = 1'b0;
        checks++; if (a_r0_valid !== 1'b0) begin errors++; $display("FAIL rb_novalid got %b want 0", a_r0_valid); end
        step();
        checks++; if (a_m_en !== 1'b1 || a_m_addr !== 32'h700) begin errors++; $display("FAIL rb_regrant got en=%b a=%h want 1/700", a_m_en, a_m_addr); end
        m_valid = 1'b1; m_rdata = 32'h0BADF00D;
        step();
        checks++; if (a_r0_valid !== 1'b1 || a_r0_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rb_complete got v=%b d=%h want 1/0badf00d", a_r0_valid, a_r0_rdata); end
        m_valid = 1'b0; r0_en = 1'b0;
        step();
    endtask

    initial begin
        res = 1'b1;
        r0_en = 1'b0; r0_rw = 1'b0; r0_be = 4'h0; r0_addr = '0; r0_wdata = '0;
        r1_en = 1'b0; r1_rw = 1'b0; r1_be = 4'h0; r1_addr = '0; r1_wdata = '0;
        m_valid = 1'b0; m_rdata = '0;
        step();
        test_reset();
        test_read();
        test_arbitration();
        test_timeout_write();
        test_timeout_edge();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
